// File: rtl/register_stack.sv
// LIFO register stack for the stack-CPU datapath.
// TOS/NOS views are decoded from registered state with zero read latency.
module register_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             in_clk,
    input  logic             in_reset_n,
    input  logic             in_push,
    input  logic             in_pop,
    input  logic [WIDTH-1:0] in_push_value,
    input  logic             in_flush,
    input  logic             in_clear_err,
    output logic [WIDTH-1:0] ot_top,
    output logic [WIDTH-1:0] ot_next,
    output logic [CNT_W-1:0] ot_count,
    output logic             ot_empty,
    output logic             ot_full,
    output logic             ot_overflow,
    output logic             ot_underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] wr_idx;
    logic             wr_en;
    logic             ovf_q;
    logic             unf_q;
    logic             ovf_set;
    logic             unf_set;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_W'(DEPTH));

    always_comb begin
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = '0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (in_flush) begin
            cnt_nxt = '0;
        end else begin
            unique case ({in_push, in_pop})
                2'b10: begin
                    if (!is_full) begin
                        wr_en   = 1'b1;
                        wr_idx  = cnt;
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                2'b11: begin
                    wr_en = 1'b1;
                    if (!is_empty) begin
                        wr_idx = cnt - CNT_W'(1);
                    end else begin
                        // illegal pop still flagged; the push lands in entry 0
                        unf_set = 1'b1;
                        wr_idx  = '0;
                        cnt_nxt = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            cnt   <= cnt_nxt;
            ovf_q <= ovf_set | (ovf_q & ~in_clear_err);
            unf_q <= unf_set | (unf_q & ~in_clear_err);
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_idx == CNT_W'(i))) begin
                    mem[i] <= in_push_value;
                end
            end
        end
    end

    // entries above count are stale after pop/flush, so mask by count
    always_comb begin
        ot_top  = '0;
        ot_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt == CNT_W'(i + 1)) begin
                ot_top = mem[i];
            end
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (cnt == CNT_W'(i + 2)) begin
                ot_next = mem[i];
            end
        end
    end

    assign ot_count     = cnt;
    assign ot_empty     = is_empty;
    assign ot_full      = is_full;
    assign ot_overflow  = ovf_q;
    assign ot_underflow = unf_q;

endmodule

// File: tb/tb_register_stack.sv
// Directed self-checking bench for register_stack.
// Covers a 16x16 instance and an 8-bit x 4 instance.
module tb_register_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A: WIDTH=16, DEPTH=16
    logic        a_rst_n, a_push, a_pop, a_flush, a_clr;
    logic [15:0] a_val;
    logic [15:0] a_top, a_next;
    logic [4:0]  a_count;
    logic        a_empty, a_full, a_ovf, a_unf;

    // instance B: WIDTH=8, DEPTH=4
    logic        b_rst_n, b_push, b_pop, b_flush, b_clr;
    logic [7:0]  b_val;
    logic [7:0]  b_top, b_next;
    logic [2:0]  b_count;
    logic        b_empty, b_full, b_ovf, b_unf;

    register_stack #(.WIDTH(16), .DEPTH(16)) u_a (
        .in_clk        (clk),
        .in_reset_n    (a_rst_n),
        .in_push       (a_push),
        .in_pop        (a_pop),
        .in_push_value (a_val),
        .in_flush      (a_flush),
        .in_clear_err  (a_clr),
        .ot_top        (a_top),
        .ot_next       (a_next),
        .ot_count      (a_count),
        .ot_empty      (a_empty),
        .ot_full       (a_full),
        .ot_overflow   (a_ovf),
        .ot_underflow  (a_unf)
    );

    register_stack #(.WIDTH(8), .DEPTH(4)) u_b (
        .in_clk        (clk),
        .in_reset_n    (b_rst_n),
        .in_push       (b_push),
        .in_pop        (b_pop),
        .in_push_value (b_val),
        .in_flush      (b_flush),
        .in_clear_err  (b_clr),
        .ot_top        (b_top),
        .ot_next       (b_next),
        .ot_count      (b_count),
        .ot_empty      (b_empty),
        .ot_full       (b_full),
        .ot_overflow   (b_ovf),
        .ot_underflow  (b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic push, input logic pop,
                          input logic [15:0] val, input logic flush,
                          input logic clr);
        a_push = push; a_pop = pop; a_val = val;
        a_flush = flush; a_clr = clr;
        @(posedge clk); #1;
        a_push = 0; a_pop = 0; a_val = '0; a_flush = 0; a_clr = 0;
    endtask

    task automatic step_b(input logic push, input logic pop,
                          input logic [7:0] val, input logic flush,
                          input logic clr);
        b_push = push; b_pop = pop; b_val = val;
        b_flush = flush; b_clr = clr;
        @(posedge clk); #1;
        b_push = 0; b_pop = 0; b_val = '0; b_flush = 0; b_clr = 0;
    endtask

    initial begin
        a_rst_n = 0; a_push = 0; a_pop = 0; a_val = '0;
        a_flush = 0; a_clr = 0;
        b_rst_n = 0; b_push = 0; b_pop = 0; b_val = '0;
        b_flush = 0; b_clr = 0;
        #2;
        chk("rst_count", 32'(a_count), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_top", 32'(a_top), 0);
        chk("rst_next", 32'(a_next), 0);
        chk("rst_flags", {30'd0, a_ovf, a_unf}, 0);
        a_rst_n = 1; b_rst_n = 1;
        @(posedge clk); #1;

        // fill
        for (int i = 1; i <= 16; i++) step_a(1, 0, 16'(i), 0, 0);
        chk("fill_full", 32'(a_full), 1);
        chk("fill_count", 32'(a_count), 16);
        chk("fill_top", 32'(a_top), 32'h10);
        chk("fill_next", 32'(a_next), 32'h0F);

        // overflow
        step_a(1, 0, 16'hBEEF, 0, 0);
        chk("ovf_flag", 32'(a_ovf), 1);
        chk("ovf_top", 32'(a_top), 32'h10);
        chk("ovf_count", 32'(a_count), 16);
        step_a(0, 0, 16'h0, 0, 1);
        chk("ovf_clr", 32'(a_ovf), 0);

        // replace on full
        step_a(1, 1, 16'hBEEF, 0, 0);
        chk("repl_top", 32'(a_top), 32'hBEEF);
        chk("repl_next", 32'(a_next), 32'h0F);
        chk("repl_count", 32'(a_count), 16);
        chk("repl_noovf", 32'(a_ovf), 0);

        // drain
        for (int k = 1; k <= 16; k++) begin
            step_a(0, 1, 16'h0, 0, 0);
            chk("drain_top", 32'(a_top), 32'(16 - k));
        end
        chk("drain_empty", 32'(a_empty), 1);
        chk("drain_flags", {30'd0, a_ovf, a_unf}, 0);

        // underflow
        step_a(0, 1, 16'h0, 0, 0);
        chk("unf_flag", 32'(a_unf), 1);
        chk("unf_count", 32'(a_count), 0);
        step_a(1, 1, 16'h1234, 0, 0);
        chk("pp_empty_unf", 32'(a_unf), 1);
        chk("pp_empty_top", 32'(a_top), 32'h1234);
        chk("pp_empty_count", 32'(a_count), 1);

        // clear race: set wins for overflow, underflow clears
        for (int i = 0; i < 15; i++) step_a(1, 0, 16'(32'h100 + i), 0, 0);
        chk("race_full", 32'(a_full), 1);
        step_a(1, 0, 16'h5555, 0, 1);
        chk("race_ovf", 32'(a_ovf), 1);
        chk("race_unf", 32'(a_unf), 0);
        step_a(0, 0, 16'h0, 0, 1);
        chk("race_clr", 32'(a_ovf), 0);

        // flush priority, flags untouched by flush
        step_a(1, 0, 16'h0, 1, 0);
        for (int i = 0; i < 3; i++) step_a(1, 0, 16'(i + 7), 0, 0);
        chk("fl_pre_count", 32'(a_count), 3);
        step_a(0, 1, 16'h0, 1, 0);
        step_a(0, 1, 16'h0, 0, 0);
        chk("fl_unf_set", 32'(a_unf), 1);
        for (int i = 0; i < 3; i++) step_a(1, 0, 16'(i + 7), 0, 0);
        step_a(1, 0, 16'h7777, 1, 0);
        chk("fl_count", 32'(a_count), 0);
        chk("fl_top", 32'(a_top), 0);
        chk("fl_flag_keep", 32'(a_unf), 1);
        step_a(1, 0, 16'h00AA, 0, 0);
        chk("fl_push_count", 32'(a_count), 1);
        chk("fl_push_top", 32'(a_top), 32'hAA);
        chk("fl_push_next", 32'(a_next), 0);

        // async reset mid-stream at count 5
        for (int i = 0; i < 4; i++) step_a(1, 0, 16'(i + 1), 0, 0);
        chk("mid_count5", 32'(a_count), 5);
        a_rst_n = 0;
        #1;
        chk("mid_rst_count", 32'(a_count), 0);
        chk("mid_rst_empty", 32'(a_empty), 1);
        chk("mid_rst_top", 32'(a_top), 0);
        chk("mid_rst_flags", {30'd0, a_ovf, a_unf}, 0);
        a_rst_n = 1;

        // instance B
        chk("b_rst_empty", 32'(b_empty), 1);
        step_b(1, 0, 8'h11, 0, 0);
        step_b(1, 0, 8'h22, 0, 0);
        step_b(1, 0, 8'h33, 0, 0);
        chk("b_count3", 32'(b_count), 3);
        chk("b_top", 32'(b_top), 32'h33);
        chk("b_next", 32'(b_next), 32'h22);
        step_b(1, 0, 8'h44, 1, 0);
        chk("b_fl_count", 32'(b_count), 0);
        chk("b_fl_top", 32'(b_top), 0);
        step_b(1, 0, 8'hAA, 0, 0);
        chk("b_push_count", 32'(b_count), 1);
        chk("b_push_top", 32'(b_top), 32'hAA);
        chk("b_push_next", 32'(b_next), 0);
        for (int i = 0; i < 3; i++) step_b(1, 0, 8'(i + 1), 0, 0);
        chk("b_full", 32'(b_full), 1);
        chk("b_count4", 32'(b_count), 4);
        step_b(1, 0, 8'hEE, 0, 0);
        chk("b_ovf", 32'(b_ovf), 1);
        chk("b_ovf_count", 32'(b_count), 4);
        chk("b_ovf_top", 32'(b_top), 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
